// File: rtl/subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The optional signed-overflow output is enabled with SUB_SIGNED_OVF_EN.
package subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SUB_DEFAULT_WIDTH = 5;

    // Bit counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor cell: d = a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock, valid/ready on both sides.
// Define SUB_SIGNED_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-2:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SUB_SIGNED_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;
    logic             last_step;

    full_subtractor u_fs (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (br_q),
        .d    (d_bit),
        .bout (br_next)
    );

    // Partial result accumulates in res_sr; diff_q only updates on the final step
    // so the visible result stays stable while the next operation is in flight.
    assign res_shift = {d_bit, res_sr_q};
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        diff_d   = diff_q;
        br_d     = br_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;
`ifdef SUB_SIGNED_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                br_d     = br_next;
                res_sr_d = res_shift[WIDTH-1:1];
                cnt_d    = cnt_q + 1'b1;
                if (last_step) begin
                    diff_d  = res_shift;
                    bout_d  = br_next;
`ifdef SUB_SIGNED_OVF_EN
                    // On the last step the shifter LSBs are the original operand MSBs.
                    ovf_d   = (a_sr_q[0] != b_sr_q[0]) && (d_bit != a_sr_q[0]);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SUB_SIGNED_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
`ifdef SUB_SIGNED_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SUB_SIGNED_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: accepted operands push a modelled result,
// an independent monitor pops and compares on every consumed output.
module tb_serial_subtractor;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, bout;
    logic [W-1:0] diff;
`ifdef SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   pops = 0;
    bit   drv_done = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic, signed view for the overflow flag.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int ux, uy, sx, sy, sd;
        ux = int'(x);
        uy = int'(y);
        e.d  = W'(((ux - uy) + (1 << W)) % (1 << W));
        e.bo = (ux < uy);
        sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
        sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
        sd = sx - sy;
        e.ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) exp_q.push_back(model(a, b));
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                pops++;
                check("sb_diff", diff, e.d);
                check("sb_bout", bout, e.bo);
`ifdef SUB_SIGNED_OVF_EN
                check("sb_ovf", ovf, e.ov);
`endif
            end
        end
    end

    // Offer one operand pair, check latency and the spec's constant result.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp_d, input logic exp_b);
        int n;
        @(posedge clk); #1;
        a = x; b = y; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("accept_wait", (n < 100), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("latency", n, W);
        check("direct_diff", diff, exp_d);
        check("direct_bout", bout, exp_b);
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    endtask

    initial begin
        exp_t hold;
        int   n, base;
        logic [W-1:0] d_hold;

        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
`ifdef SUB_SIGNED_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;

        send(5'd13, 5'd6, 5'd7, 1'b0);
        send(5'd6, 5'd13, 5'd25, 1'b1);
        send(5'd0, 5'd1, 5'd31, 1'b1);
        send(5'd31, 5'd31, 5'd0, 1'b0);
`ifdef SUB_SIGNED_OVF_EN
        send(5'd15, 5'd16, 5'd31, 1'b1);
        send(5'd16, 5'd1, 5'd15, 1'b0);
        send(5'd3, 5'd5, 5'd30, 1'b1);
`endif

        // Backpressure: hold in DONE with new operands waiting.
        out_ready = 1'b0;
        send(5'd7, 5'd2, 5'd5, 1'b0);
        hold = model(5'd7, 5'd2);
        a = 5'd11; b = 5'd4; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_diff", diff, hold.d);
            check("bp_bout", bout, hold.bo);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_new_accept", in_ready, 0);
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("bp_drain", (n < 100), 1);

        // Reset in the middle of an operation.
        a = 5'd20; b = 5'd9; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_diff", diff, 0);
        check("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        send(5'd9, 5'd20, 5'd21, 1'b1);

        // Randomized traffic with gaps on both sides.
        base = pops;
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    int g;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
                    g = 0;
                    forever begin
                        @(negedge clk);
                        g++;
                        if (in_ready || g > 200) break;
                    end
                    if (g > 200) check("rand_accept_timeout", 1, 0);
                    @(posedge clk); #1 in_valid = 1'b0;
                end
                drv_done = 1;
            end
            begin
                int guard = 0;
                while (!(drv_done && exp_q.size() == 0) && guard < 20000) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 1) == 1);
                    guard++;
                end
                out_ready = 1'b1;
            end
        join
        check("rand_all_consumed", pops - base, 50);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing `diff = a - b` modulo 2^WIDTH, plus a borrow-out, one bit per clock, LSB first. It is the inverse-operation companion to the team's combinational ripple-carry adders. It sits in the arithmetic datapath where area matters more than latency. Operands enter and results leave through independent valid/ready handshakes.

## Interface
- `WIDTH`, default 5: operand and result width in bits; legal range 2..32.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  block can accept operands; equals (state == IDLE).
- `a`  in  WIDTH  minuend, unsigned.
- `b`  in  WIDTH  subtrahend, unsigned.
- `out_valid`  out  1  result available; equals (state == DONE).
- `out_ready`  in  1  consumer takes the result.
- `diff`  out  WIDTH  registered (a - b) mod 2^WIDTH.
- `bout`  out  1  registered final borrow; 1 iff a < b.
- `ovf`  out  1  signed overflow; port exists only with `SUB_SIGNED_OVF_EN`.

## Operation
- FSM states: IDLE, BUSY, DONE, held in a registered state variable.
- IDLE: on `in_valid && in_ready`, capture `a` and `b` into shift registers, clear the borrow, clear the bit counter, and go to BUSY. No capture happens otherwise.
- BUSY, each cycle: one full-subtractor step on the operand LSBs and the borrow:
  - d = a0 ^ b0 ^ br
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d shifts into the `diff` MSB, and the operands shift right.
  - Counter increments. When counter == WIDTH-1, go to DONE.
- DONE: `diff` and `bout` are stable. On `out_valid && out_ready`, go to IDLE.
- `diff` and `bout` keep their last values in IDLE and BUSY. Only the DONE state qualifies them.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- Arithmetic is unsigned modulo 2^WIDTH.
  - `bout` equals the borrow out of the MSB step.
  - `a == b` gives `diff` = 0 and `bout` = 0.
- Reset is asynchronous and may occur mid-operation. It discards any operation in flight and forces IDLE. All registers clear.

## Timing
- Reset values: state IDLE, so `in_ready` = 1 and `out_valid` = 0; `diff` = 0, `bout` = 0, `ovf` = 0.
- Accept at edge T. BUSY is active for edges T+1 through T+WIDTH. `out_valid` is high from edge T+WIDTH.
  - Latency is WIDTH cycles from accept to `out_valid`.
- Results are consumed at the first edge where `out_valid && out_ready`.
  - `in_ready` rises the same edge.
  - The earliest next accept is one cycle later.
  - Throughput is one result per WIDTH+2 cycles.
- Backpressure: while `out_ready` = 0 in DONE, `diff`, `bout` and `ovf` hold exactly.
- No combinational path from inputs to outputs. `in_ready` and `out_valid` decode only registered state.

## Configuration
- `SUB_SIGNED_OVF_EN` defined: adds output `ovf` and its register.
  - `ovf` = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from the captured operand MSBs at the final BUSY step.
  - `ovf` is valid in DONE and cleared by reset.
- `SUB_SIGNED_OVF_EN` undefined: no `ovf` port and no related logic. All other behaviour is identical.

## Structure
- Package `subtractor_pkg`:
  - state enum `sub_state_t` (IDLE, BUSY, DONE);
  - `SUB_DEFAULT_WIDTH` = 5;
  - counter-width helper function (clog2 of WIDTH).
- Sub-module `full_subtractor`: combinational 1-bit cell with inputs (a, b, bin) and outputs (d, bout), instantiated once in the BUSY datapath.

## Test plan
- Reset, then `a`=13, `b`=6 offered with `out_ready`=1 -> `out_valid` rises exactly 5 cycles after accept; `diff`=7, `bout`=0, `ovf`=0.
- `a`=6, `b`=13 -> `diff`=25, `bout`=1. `a`=0, `b`=1 -> `diff`=31, `bout`=1. `a`=31, `b`=31 -> `diff`=0, `bout`=0.
- With `SUB_SIGNED_OVF_EN`: `a`=15, `b`=16 -> `diff`=31, `bout`=1, `ovf`=1. `a`=16, `b`=1 -> `diff`=15, `ovf`=1. `a`=3, `b`=5 -> `ovf`=0.
- Backpressure: `out_ready`=0 for 3 cycles in DONE with `in_valid` held high and new operands -> outputs frozen and `in_ready`=0. Release -> IDLE next edge, then new operands accepted.
- Reset mid-operation: assert `rst_n`=0 two cycles after accepting `a`=20, `b`=9 -> immediately `out_valid`=0, `diff`=0, `in_ready`=1. After release, `a`=9, `b`=20 -> `diff`=21, `bout`=1.
- Back-to-back: 50 random operand pairs with random `in_valid`/`out_ready` gaps -> every result matches the (a - b) mod 32 model, with no drops and no duplicates.
